// File: rtl/led_pwm_pkg.sv
// Shared constants and types for the LED PWM brightness controller.
// Used by led_pwm_timebase and led_pwm_ctrl.
package led_pwm_pkg;

  localparam int NUM_LEDS  = 16;
  localparam int BRIGHT_W  = 4;
  localparam int PHASE_W   = 4;
  localparam int PWM_STEPS = 15;

  typedef enum logic [1:0] {
    REG_CTRL      = 2'd0,
    REG_BRIGHT_LO = 2'd1,
    REG_BRIGHT_HI = 2'd2,
    REG_STATUS    = 2'd3
  } reg_addr_t;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_BREATHE_BIT = 1;

  typedef logic [BRIGHT_W-1:0] bright_t;

  function automatic bright_t bright_min(input bright_t a, input bright_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// PWM timebase: prescaler plus a 0..PWM_STEPS-1 phase counter.
// step pulses once every PRESCALE clocks; period_end marks the step that wraps phase to 0.
module led_pwm_timebase
  import led_pwm_pkg::*;
#(
  parameter int PRESCALE = 64
) (
  input  logic               clk,
  input  logic               resetn,
  output logic [PHASE_W-1:0] phase,
  output logic               step,
  output logic               period_end
);

  localparam int                 CNT_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(PRESCALE - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PWM_STEPS - 1);

  // cnt holds the clocks remaining before the next step; terminal count is zero
  logic [CNT_W-1:0] cnt;

  assign step       = (cnt == '0);
  assign period_end = step && (phase == PHASE_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= CNT_LOAD;
      phase <= '0;
    end else begin
      if (step) begin
        cnt   <= CNT_LOAD;
        phase <= period_end ? '0 : phase + 1'b1;
      end else begin
        cnt   <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_pwm_ctrl.sv
// Memory-mapped per-LED PWM brightness controller for 16 board LEDs.
// Optional breathing fade is compiled in with LED_PWM_BREATHE_EN.
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int      PRESCALE     = 64,
  parameter bright_t RESET_BRIGHT = 4'hF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [1:0]          addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  input  logic [NUM_LEDS-1:0] leds_i,
  output logic [NUM_LEDS-1:0] leds_o
);

  logic                               en;
  logic [NUM_LEDS-1:0][BRIGHT_W-1:0] bright;
  logic [NUM_LEDS-1:0][BRIGHT_W-1:0] eff_bright;
  logic [PHASE_W-1:0]                 phase;
  logic                               step;
  logic                               period_end;
  logic [BRIGHT_W-1:0]                fade_lvl;
  logic                               breathe_rd;
  logic [31:0]                        rd_mux;
  logic [NUM_LEDS-1:0]                lit;
  logic                               unused_step;

  led_pwm_timebase #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk        (clk),
    .resetn     (resetn),
    .phase      (phase),
    .step       (step),
    .period_end (period_end)
  );

  assign unused_step = step;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en     <= 1'b1;
      bright <= {NUM_LEDS{RESET_BRIGHT}};
    end else if (wr_en) begin
      case (addr)
        REG_CTRL:      en            <= wdata[CTRL_EN_BIT];
        REG_BRIGHT_LO: bright[7:0]   <= wdata;
        REG_BRIGHT_HI: bright[15:8]  <= wdata;
        default:       ;
      endcase
    end
  end

`ifdef LED_PWM_BREATHE_EN
  logic    breathe;
  bright_t fade;
  logic    fade_up;

  // fade holds each level for one full PWM period, ping-ponging 0..15..0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      breathe <= 1'b0;
      fade    <= '0;
      fade_up <= 1'b1;
    end else begin
      if (wr_en && (addr == REG_CTRL))
        breathe <= wdata[CTRL_BREATHE_BIT];
      if (breathe && period_end) begin
        if (fade_up) begin
          if (fade == '1) begin
            fade_up <= 1'b0;
            fade    <= fade - 1'b1;
          end else begin
            fade    <= fade + 1'b1;
          end
        end else begin
          if (fade == '0) begin
            fade_up <= 1'b1;
            fade    <= fade + 1'b1;
          end else begin
            fade    <= fade - 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    eff_bright = bright;
    if (breathe) begin
      for (int n = 0; n < NUM_LEDS; n++)
        eff_bright[n] = bright_min(bright[n], fade);
    end
  end

  assign fade_lvl   = fade;
  assign breathe_rd = breathe;
`else
  logic unused_period_end;

  assign unused_period_end = period_end;
  assign eff_bright        = bright;
  assign fade_lvl          = '0;
  assign breathe_rd        = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (addr)
      REG_CTRL: begin
        rd_mux[CTRL_EN_BIT]      = en;
        rd_mux[CTRL_BREATHE_BIT] = breathe_rd;
      end
      REG_BRIGHT_LO: rd_mux      = bright[7:0];
      REG_BRIGHT_HI: rd_mux      = bright[15:8];
      REG_STATUS:    rd_mux[7:0] = {fade_lvl, phase};
      default:       rd_mux      = '0;
    endcase
  end

  // rd_mux samples pre-edge state, so a same-cycle write is not yet visible
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      rdata <= '0;
    else if (rd_en)
      rdata <= rd_mux;
  end

  always_comb begin
    lit = '0;
    for (int n = 0; n < NUM_LEDS; n++)
      lit[n] = en & leds_i[n] & (phase < eff_bright[n]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      leds_o <= '0;
    else
      leds_o <= lit;
  end

endmodule
